// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: channel map and default sizing for the input debouncer.
package input_debouncer_pkg;
    localparam int INPUT_CHANNELS         = 9;
    localparam int DEFAULT_DEBOUNCE_WIDTH = 8;
    localparam int DEFAULT_TICK_DIV_WIDTH = 10;
    typedef enum logic [3:0] {
        CH_SER = 4'd0,
        CH_A   = 4'd1,
        CH_B   = 4'd2,
        CH_C   = 4'd3,
        CH_D   = 4'd4,
        CH_E   = 4'd5,
        CH_F   = 4'd6,
        CH_G   = 4'd7,
        CH_H   = 4'd8
    } channel_e;
endpackage

// File: rtl/input_debouncer_channel.sv
// debounce_channel: one channel's persistence counter, debounced level and edge set pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      sample,
    input  logic [DEBOUNCE_WIDTH-1:0] eff_thr,
    output logic                      stable,
    output logic                      rise,
    output logic                      fall
);
    logic [DEBOUNCE_WIDTH-1:0] count;
    logic [DEBOUNCE_WIDTH:0]   count_inc;
    logic                      accept;
    // One extra bit so an all-ones threshold never wraps the compare
    assign count_inc = {1'b0, count} + (DEBOUNCE_WIDTH+1)'(1);
    assign accept    = tick && (sample != stable) && (count_inc >= {1'b0, eff_thr});
    assign rise      = accept && sample;
    assign fall      = accept && !sample;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            stable <= accept ? sample : stable;
            count  <= (sample == stable || accept) ? '0 : count_inc[DEBOUNCE_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: per-channel debounce with sticky edge flags and a masked level irq.
// Define INPUT_DEBOUNCER_SYNC_EN to add a 2-FF synchroniser on raw_in.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int CHANNELS       = INPUT_CHANNELS,
    parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH,
    parameter int TICK_DIV_WIDTH = DEFAULT_TICK_DIV_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       raw_in,
    input  logic [DEBOUNCE_WIDTH-1:0] debounce_threshold,
    input  logic [CHANNELS-1:0]       flag_clear,
    input  logic [CHANNELS-1:0]       irq_enable,
    output logic [CHANNELS-1:0]       stable_out,
    output logic [CHANNELS-1:0]       rise_flags,
    output logic [CHANNELS-1:0]       fall_flags,
    output logic                      irq
);
    logic [TICK_DIV_WIDTH-1:0] prescale;
    logic                      tick;
    logic [DEBOUNCE_WIDTH-1:0] eff_thr;
    logic [CHANNELS-1:0]       sample;
    logic [CHANNELS-1:0]       rise_set;
    logic [CHANNELS-1:0]       fall_set;
    assign tick    = &prescale;
    assign eff_thr = (debounce_threshold == '0) ? DEBOUNCE_WIDTH'(1) : debounce_threshold;
`ifdef INPUT_DEBOUNCER_SYNC_EN
    logic [CHANNELS-1:0] sync_q1;
    logic [CHANNELS-1:0] sync_q2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end
    assign sample = sync_q2;
`else
    assign sample = raw_in;
`endif
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        debounce_channel #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sample (sample[c]),
            .eff_thr(eff_thr),
            .stable (stable_out[c]),
            .rise   (rise_set[c]),
            .fall   (fall_set[c])
        );
    end
    // A set pulse overrides a clear arriving on the same clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale   <= '0;
            rise_flags <= '0;
            fall_flags <= '0;
            irq        <= 1'b0;
        end else begin
            prescale   <= prescale + TICK_DIV_WIDTH'(1);
            rise_flags <= (rise_flags & ~flag_clear) | rise_set;
            fall_flags <= (fall_flags & ~flag_clear) | fall_set;
            irq        <= |((rise_flags | fall_flags) & irq_enable);
        end
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench comparing the debouncer against a tick/run-length reference model.
module tb_input_debouncer;
    import input_debouncer_pkg::*;
    localparam int N   = INPUT_CHANNELS;
    localparam int DW  = 8;
    localparam int TW  = 2;
    localparam int PER = 1 << TW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  raw_in = '0;
    logic [DW-1:0] debounce_threshold = 8'd3;
    logic [N-1:0]  flag_clear = '0;
    logic [N-1:0]  irq_enable = '0;
    logic [N-1:0]  stable_out;
    logic [N-1:0]  rise_flags;
    logic [N-1:0]  fall_flags;
    logic          irq;

    input_debouncer #(.CHANNELS(N), .DEBOUNCE_WIDTH(DW), .TICK_DIV_WIDTH(TW)) dut (
        .clk               (clk),
        .reset             (reset),
        .raw_in            (raw_in),
        .debounce_threshold(debounce_threshold),
        .flag_clear        (flag_clear),
        .irq_enable        (irq_enable),
        .stable_out        (stable_out),
        .rise_flags        (rise_flags),
        .fall_flags        (fall_flags),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] st;
        logic [N-1:0] rf;
        logic [N-1:0] ff;
        logic         irq;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: counts clocks since reset and, on every PER-th clock, the run of
    // consecutive ticks whose sample disagrees with the accepted level.
    int           cyc_m = 0;
    int           run_m[N];
    int           thr_m;
    logic [N-1:0] st_m = '0, rf_m = '0, ff_m = '0, h1 = '0, h2 = '0, s_m;
    logic         irq_m = 1'b0, nxt_irq;

    always @(posedge clk) begin
        if (reset) begin
            cyc_m = 0;
            st_m  = '0;
            rf_m  = '0;
            ff_m  = '0;
            irq_m = 1'b0;
            h1    = '0;
            h2    = '0;
            for (int i = 0; i < N; i++) run_m[i] = 0;
        end else begin
`ifdef INPUT_DEBOUNCER_SYNC_EN
            s_m = h2;
            h2  = h1;
            h1  = raw_in;
`else
            s_m = raw_in;
`endif
            nxt_irq = |((rf_m | ff_m) & irq_enable);
            rf_m    = rf_m & ~flag_clear;
            ff_m    = ff_m & ~flag_clear;
            thr_m   = (debounce_threshold == 0) ? 1 : int'(debounce_threshold);
            if (cyc_m % PER == PER - 1) begin
                for (int i = 0; i < N; i++) begin
                    if (s_m[i] != st_m[i]) begin
                        run_m[i]++;
                        if (run_m[i] >= thr_m) begin
                            st_m[i]  = s_m[i];
                            run_m[i] = 0;
                            if (s_m[i]) rf_m[i] = 1'b1;
                            else        ff_m[i] = 1'b1;
                        end
                    end else begin
                        run_m[i] = 0;
                    end
                end
            end
            irq_m = nxt_irq;
            cyc_m++;
        end
        q.push_back('{st: st_m, rf: rf_m, ff: ff_m, irq: irq_m});
    end

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (reset) e = '0;
            check("stable_out", stable_out, e.st);
            check("rise_flags", rise_flags, e.rf);
            check("fall_flags", fall_flags, e.ff);
            check("irq", {{(N-1){1'b0}}, irq}, {{(N-1){1'b0}}, e.irq});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Leaves the bench just after an edge such that the next edge is a tick
    task automatic align_tick();
        for (int k = 0; k < 2 * PER && (cyc_m % PER) != PER - 1; k++) cyc(1);
    endtask

    initial begin
        raw_in     = '1;
        irq_enable = '1;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        flag_clear = '1;
        cyc(1);
        flag_clear = '0;
        raw_in     = '0;
        irq_enable = '0;
        cyc(20);
        flag_clear = '1;
        cyc(1);
        flag_clear = '0;
        irq_enable = '1;
        // glitch on channel 2
        align_tick();
        raw_in[2] = 1'b1;
        cyc(2 * PER);
        raw_in[2] = 1'b0;
        cyc(4 * PER);
        // set/clear collision on channel 1
        raw_in[1] = 1'b1;
        cyc(4 * PER);
        flag_clear = '1;
        cyc(1);
        flag_clear = '0;
        align_tick();
        raw_in[1] = 1'b0;
        cyc(2 * PER);
        flag_clear[1] = 1'b1;
        cyc(2);
        flag_clear[1] = 1'b0;
        cyc(PER);
        // threshold 0 behaves as 1
        debounce_threshold = 8'd0;
        align_tick();
        raw_in[8] = 1'b1;
        cyc(PER);
        debounce_threshold = 8'd3;
        // mask then enable channel 4
        irq_enable = '0;
        flag_clear = '1;
        cyc(1);
        flag_clear = '0;
        raw_in[4] = 1'b1;
        cyc(4 * PER);
        irq_enable[4] = 1'b1;
        cyc(PER);
        // reset in the middle of a count on channel 5
        align_tick();
        raw_in[5] = 1'b1;
        cyc(2 * PER);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(5 * PER);
        // randomized traffic
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 29) == 0) raw_in[i] = ~raw_in[i];
            if ($urandom_range(0, 99) == 0) debounce_threshold = DW'($urandom_range(0, 4));
            flag_clear = ($urandom_range(0, 9) == 0) ? N'($urandom & $urandom) : '0;
            if ($urandom_range(0, 49) == 0) irq_enable = N'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(3);
        if (checks == 0) begin
            errors++;
            $display("FAIL no_checks: got 0 comparisons, expected more than 0");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
